chunked_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor, the clocked successor to the team's 4-bit ripple carry adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling the carry between chunks through a register, so wide adds close timing at the cost of latency. It uses a start/busy/done handshake and reports carry-out and signed overflow. It sits between operand registers and any datapath consumer that can tolerate WIDTH/CHUNK cycles of latency.

---
 rtl/chunked_adder.sv | 106 ++++++++++
 tb/tb_chunked_adder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle add/subtract, CHUNK bits per clock.
// Carry ripples between chunks through a register; start/busy/done handshake.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res;
  logic             carry;

  int               lo;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK:0]   ch_sum;
  logic [WIDTH-1:0] res_nx;
  logic             last;
  logic             ovf_nx;

  // Current chunk sum and the result with that chunk merged in
  always_comb begin
    lo     = int'(idx) * CHUNK;
    a_ch   = a_r[lo +: CHUNK];
    b_ch   = b_r[lo +: CHUNK];
    ch_sum = {1'b0, a_ch} + {1'b0, b_ch}
           + {{CHUNK{1'b0}}, carry};
    res_nx = res;
    res_nx[lo +: CHUNK] = ch_sum[CHUNK-1:0];
    last   = (idx == IW'(N - 1));
    // same-sign operands giving a different-sign result
    ovf_nx = (a_ch[CHUNK-1] == b_ch[CHUNK-1])
          && (ch_sum[CHUNK-1] != a_ch[CHUNK-1]);
  end

  // Control FSM, chunk datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      res   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_r   <= A;
            b_r   <= B ^ {WIDTH{sub}};
            carry <= Cin ^ sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res   <= res_nx;
          carry <= ch_sum[CHUNK];
          if (last) begin
            Sum   <= res_nx;
            Cout  <= ch_sum[CHUNK];
            ovf   <= ovf_nx;
            done  <= 1'b1;
            busy  <= 1'b0;
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: scoreboard bench for chunked_adder.
// Three instances: 16/4 directed + random, 4/1 and 4/4 exhaustive.
module tb_chunked_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic        s0, c0, u0;
  logic [15:0] a0, b0;
  logic        busy0, done0, co0, ov0;
  logic [15:0] sum0;

  logic        s4, c4, u4;
  logic [3:0]  a4, b4;
  logic        busy1, done1, co1, ov1;
  logic [3:0]  sum1;
  logic        busy2, done2, co2, ov2;
  logic [3:0]  sum2;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) d0 (
    .clk(clk), .rst(rst), .start(s0), .A(a0), .B(b0),
    .Cin(c0), .sub(u0), .busy(busy0), .done(done0),
    .Sum(sum0), .Cout(co0), .ovf(ov0)
  );

  chunked_adder #(.WIDTH(4), .CHUNK(1)) d1 (
    .clk(clk), .rst(rst), .start(s4), .A(a4), .B(b4),
    .Cin(c4), .sub(u4), .busy(busy1), .done(done1),
    .Sum(sum1), .Cout(co1), .ovf(ov1)
  );

  chunked_adder #(.WIDTH(4), .CHUNK(4)) d2 (
    .clk(clk), .rst(rst), .start(s4), .A(a4), .B(b4),
    .Cin(c4), .sub(u4), .busy(busy2), .done(done2),
    .Sum(sum2), .Cout(co2), .ovf(ov2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // exact-integer reference: unsigned for sum/carry, signed for overflow
  function automatic exp_t model(input int w, input int a,
                                 input int b, input bit cin,
                                 input bit sub);
    exp_t   e;
    longint full, sa, sb, sr, hi, lo, half, span;
    half = longint'(1) << (w - 1);
    span = longint'(1) << w;
    sa   = (a >= half) ? a - span : longint'(a);
    sb   = (b >= half) ? b - span : longint'(b);
    if (!sub) begin
      full   = longint'(a) + b + cin;
      sr     = sa + sb + cin;
      e.cout = (full >= span);
    end else begin
      full   = longint'(a) - b - cin;
      sr     = sa - sb - cin;
      e.cout = (longint'(a) >= longint'(b) + cin);
    end
    hi    = half - 1;
    lo    = -half;
    e.ovf = (sr > hi) || (sr < lo);
    e.sum = 16'(full & (span - 1));
    e.acc = 0;
    return e;
  endfunction

  // scoreboard pop for the 16/4 instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done0) begin
      chk("d0 busy@done", 32'(busy0), 0);
      chk("d0 pending", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("d0 sum", 32'(sum0), 32'(e.sum));
        chk("d0 cout", 32'(co0), 32'(e.cout));
        chk("d0 ovf", 32'(ov0), 32'(e.ovf));
        chk("d0 latency", 32'(cyc - e.acc), 4);
      end
    end
  end

  // scoreboard pop for the 4/1 instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done1) begin
      chk("d1 busy@done", 32'(busy1), 0);
      chk("d1 pending", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("d1 sum", 32'(sum1), 32'(e.sum));
        chk("d1 cout", 32'(co1), 32'(e.cout));
        chk("d1 ovf", 32'(ov1), 32'(e.ovf));
        chk("d1 latency", 32'(cyc - e.acc), 4);
      end
    end
  end

  // scoreboard pop for the 4/4 instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done2) begin
      chk("d2 busy@done", 32'(busy2), 0);
      chk("d2 pending", 32'(q2.size() != 0), 1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        chk("d2 sum", 32'(sum2), 32'(e.sum));
        chk("d2 cout", 32'(co2), 32'(e.cout));
        chk("d2 ovf", 32'(ov2), 32'(e.ovf));
        chk("d2 latency", 32'(cyc - e.acc), 1);
      end
    end
  end

  task automatic go0(input logic [15:0] a, input logic [15:0] b,
                     input logic cin, input logic sub,
                     input logic [15:0] es, input logic eco,
                     input logic eov);
    exp_t e;
    a0 = a; b0 = b; c0 = cin; u0 = sub; s0 = 1'b1;
    e.sum = es; e.cout = eco; e.ovf = eov; e.acc = cyc + 1;
    q0.push_back(e);
    @(negedge clk);
    s0 = 1'b0;
  endtask

  task automatic drain0();
    for (int i = 0; i < 20 && q0.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("d0 drain", 32'(q0.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    exp_t e1, e2, e;
    int   nb;
    logic [15:0] ra, rb;
    logic rc, rs;
    s0 = 0; a0 = 0; b0 = 0; c0 = 0; u0 = 0;
    s4 = 0; a4 = 0; b4 = 0; c4 = 0; u4 = 0;
    #1;
    chk("rst busy", 32'(busy0), 0);
    chk("rst done", 32'(done0), 0);
    chk("rst sum", 32'(sum0), 0);
    chk("rst cout", 32'(co0), 0);
    chk("rst ovf", 32'(ov0), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // basic add, busy window
    go0(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy0) nb++;
      @(negedge clk);
    end
    chk("busy cycles", 32'(nb), 4);
    drain0();

    go0(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drain0();
    go0(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    drain0();
    go0(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    drain0();
    go0(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    drain0();

    // random 16-bit ops against the model
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      e  = model(16, int'(ra), int'(rb), rc, rs);
      go0(ra, rb, rc, rs, e.sum, e.cout, e.ovf);
      drain0();
    end

    // start held while busy, operands changed mid-flight
    e1 = model(16, 'hABCD, 'h1357, 1'b1, 1'b0);
    e1.acc = cyc + 1;
    a0 = 16'hABCD; b0 = 16'h1357; c0 = 1'b1; u0 = 1'b0;
    s0 = 1'b1;
    q0.push_back(e1);
    @(negedge clk);
    @(negedge clk);
    a0 = 16'h0101; b0 = 16'h0202; c0 = 1'b0; u0 = 1'b1;
    e2 = model(16, 'h0101, 'h0202, 1'b0, 1'b1);
    for (int i = 0; i < 10 && !done0; i++) @(negedge clk);
    chk("hs done seen", 32'(done0), 1);
    e2.acc = cyc + 1;
    q0.push_back(e2);
    @(negedge clk);
    s0 = 1'b0;
    drain0();

    // reset in the middle of an add
    a0 = 16'h4321; b0 = 16'h1111; c0 = 1'b0; u0 = 1'b0;
    s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sum held", 32'(sum0), 32'(e2.sum));
    chk("busy mid", 32'(busy0), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst busy", 32'(busy0), 0);
    chk("arst done", 32'(done0), 0);
    chk("arst sum", 32'(sum0), 0);
    chk("arst cout", 32'(co0), 0);
    chk("arst ovf", 32'(ov0), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    go0(16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0);
    drain0();

    // exhaustive 4-bit sweep on both small instances
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int ci = 0; ci < 2; ci++)
          for (int sb = 0; sb < 2; sb++) begin
            a4 = 4'(a); b4 = 4'(b);
            c4 = 1'(ci); u4 = 1'(sb);
            s4 = 1'b1;
            e = model(4, a, b, 1'(ci), 1'(sb));
            e.acc = cyc + 1;
            q1.push_back(e);
            q2.push_back(e);
            @(negedge clk);
            s4 = 1'b0;
            repeat (5) @(negedge clk);
          end
    @(negedge clk);
    chk("d1 drain", 32'(q1.size()), 0);
    chk("d2 drain", 32'(q2.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
